// File: rtl/of_ex_pipe_reg.sv
// of_ex_pipe_reg: OF->EX pipeline register with stall, flush-to-bubble and saturating bubble counter
module of_ex_pipe_reg #(
  parameter int PC_W = 10,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_IR = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              of_valid,
  input  logic [PC_W-1:0]   of_pc,
  input  logic [DATA_W-1:0] of_branch_target,
  input  logic [DATA_W-1:0] of_op_a,
  input  logic [DATA_W-1:0] of_op_b,
  input  logic [DATA_W-1:0] of_op_2,
  input  logic [DATA_W-1:0] of_ir,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              clr_count,
  output logic              of_ready,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_branch_target,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_op_2,
  output logic [DATA_W-1:0] ex_ir,
  output logic [CNT_W-1:0]  bubble_count
);
  logic bubble;
  assign of_ready = !ex_stall;
  assign bubble = flush || (!ex_stall && !of_valid);
  // Payload register: flush beats stall beats load; bubbles only touch valid and IR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_branch_target <= '0;
      ex_op_a <= '0;
      ex_op_b <= '0;
      ex_op_2 <= '0;
      ex_ir <= NOP_IR;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ir <= NOP_IR;
    end else if (!ex_stall) begin
      ex_valid <= 1'b1;
      ex_pc <= of_pc;
      ex_branch_target <= of_branch_target;
      ex_op_a <= of_op_a;
      ex_op_b <= of_op_b;
      ex_op_2 <= of_op_2;
      ex_ir <= of_ir;
    end
  end
  // Bubble counter: clear wins, otherwise count bubble edges and stick at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bubble_count <= '0;
    else if (clr_count) bubble_count <= '0;
    else if (bubble && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
  end
endmodule

// File: tb/tb_of_ex_pipe_reg.sv
// tb_of_ex_pipe_reg: vector table, corner sequences and random run against a reference model
module tb_of_ex_pipe_reg;
  localparam logic [31:0] NOP2 = 32'h0000_0013;
  logic clk = 0, reset_n = 0;
  logic of_valid = 0, ex_stall = 0, flush = 0, clr_count = 0;
  logic [9:0] of_pc = '0;
  logic [31:0] of_branch_target = '0, of_op_a = '0, of_op_b = '0, of_op_2 = '0, of_ir = '0;
  logic of_ready, ex_valid, s_ready, s_valid;
  logic [9:0] ex_pc, s_pc;
  logic [31:0] ex_branch_target, ex_op_a, ex_op_b, ex_op_2, ex_ir;
  logic [31:0] s_bt, s_a, s_b, s_2, s_ir;
  logic [15:0] bubble_count;
  logic [2:0] s_cnt;
  int passed = 0, total = 0;
  logic m_valid;
  logic [9:0] m_pc;
  logic [31:0] m_bt, m_a, m_b, m_2, m_ir, m_ir_s;
  int m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  of_ex_pipe_reg dut (
    .clk(clk), .reset_n(reset_n), .of_valid(of_valid), .of_pc(of_pc),
    .of_branch_target(of_branch_target), .of_op_a(of_op_a), .of_op_b(of_op_b),
    .of_op_2(of_op_2), .of_ir(of_ir), .ex_stall(ex_stall), .flush(flush),
    .clr_count(clr_count), .of_ready(of_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_branch_target(ex_branch_target), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_op_2(ex_op_2), .ex_ir(ex_ir), .bubble_count(bubble_count)
  );

  of_ex_pipe_reg #(.CNT_W(3), .NOP_IR(NOP2)) dut_s (
    .clk(clk), .reset_n(reset_n), .of_valid(of_valid), .of_pc(of_pc),
    .of_branch_target(of_branch_target), .of_op_a(of_op_a), .of_op_b(of_op_b),
    .of_op_2(of_op_2), .of_ir(of_ir), .ex_stall(ex_stall), .flush(flush),
    .clr_count(clr_count), .of_ready(s_ready), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_branch_target(s_bt), .ex_op_a(s_a), .ex_op_b(s_b),
    .ex_op_2(s_2), .ex_ir(s_ir), .bubble_count(s_cnt)
  );

  typedef struct {
    logic fl, st, v, clr;
    logic [9:0] pc;
    logic [31:0] ir, a;
    logic ev;
    logic [9:0] epc;
    logic [31:0] eir, ea;
    int ecnt;
  } vec_t;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic model_reset;
    m_valid = 0; m_pc = '0; m_bt = '0; m_a = '0; m_b = '0; m_2 = '0;
    m_ir = '0; m_ir_s = NOP2; m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic model_update;
    bit bub;
    bub = flush || (!ex_stall && !of_valid);
    if (clr_count) begin m_cnt = 0; m_cnt_s = 0; end
    else if (bub) begin
      m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      m_cnt_s = (m_cnt_s + 1 > 7) ? 7 : m_cnt_s + 1;
    end
    if (bub) begin m_valid = 0; m_ir = '0; m_ir_s = NOP2; end
    else if (!ex_stall) begin
      m_valid = 1; m_pc = of_pc; m_bt = of_branch_target; m_a = of_op_a;
      m_b = of_op_b; m_2 = of_op_2; m_ir = of_ir; m_ir_s = of_ir;
    end
  endtask

  task automatic drive(logic fl, logic st, logic v, logic clr, logic [9:0] pc, logic [31:0] ir, logic [31:0] a);
    flush = fl; ex_stall = st; of_valid = v; clr_count = clr; of_pc = pc; of_ir = ir;
    of_op_a = a; of_op_b = ~a; of_op_2 = a ^ ir; of_branch_target = {22'd0, pc} * 3;
  endtask

  task automatic step;
    @(posedge clk);
    if (reset_n) model_update();
    @(negedge clk);
  endtask

  task automatic check_model;
    chk("valid", ex_valid, m_valid); chk("pc", ex_pc, m_pc);
    chk("target", ex_branch_target, m_bt); chk("op_a", ex_op_a, m_a);
    chk("op_b", ex_op_b, m_b); chk("op_2", ex_op_2, m_2);
    chk("ir", ex_ir, m_ir); chk("count", bubble_count, m_cnt);
    chk("s_ir", s_ir, m_ir_s); chk("s_count", s_cnt, m_cnt_s);
  endtask

  task automatic check_reset;
    chk("rst_valid", ex_valid, 0); chk("rst_pc", ex_pc, 0);
    chk("rst_target", ex_branch_target, 0); chk("rst_op_a", ex_op_a, 0);
    chk("rst_op_b", ex_op_b, 0); chk("rst_op_2", ex_op_2, 0);
    chk("rst_ir", ex_ir, 0); chk("rst_count", bubble_count, 0);
    chk("rst_s_ir", s_ir, NOP2); chk("rst_s_count", s_cnt, 0);
  endtask

  initial begin
    vec_t tbl[17];
    tbl[0]  = '{0,0,1,0,10,32'h1111_0001,32'd1,       1,10,32'h1111_0001,32'd1,0};
    tbl[1]  = '{0,0,1,0,11,32'h1111_0002,32'd2,       1,11,32'h1111_0002,32'd2,0};
    tbl[2]  = '{0,0,1,0,12,32'h1111_0003,32'd3,       1,12,32'h1111_0003,32'd3,0};
    tbl[3]  = '{0,0,1,0,20,32'h20,32'hDEAD_BEEF,      1,20,32'h20,32'hDEAD_BEEF,0};
    tbl[4]  = '{0,1,1,0,21,32'h21,32'hCAFE,           1,20,32'h20,32'hDEAD_BEEF,0};
    tbl[5]  = '{0,1,1,0,21,32'h21,32'hCAFE,           1,20,32'h20,32'hDEAD_BEEF,0};
    tbl[6]  = '{0,1,1,0,21,32'h21,32'hCAFE,           1,20,32'h20,32'hDEAD_BEEF,0};
    tbl[7]  = '{0,0,1,0,21,32'h21,32'hCAFE,           1,21,32'h21,32'hCAFE,0};
    tbl[8]  = '{0,0,1,0,30,32'h30,32'd5,              1,30,32'h30,32'd5,0};
    tbl[9]  = '{1,1,1,0,31,32'h31,32'd6,              0,30,32'h0,32'd5,1};
    tbl[10] = '{0,0,0,1,32,32'h32,32'd7,              0,30,32'h0,32'd5,0};
    tbl[11] = '{0,0,0,0,33,32'h33,32'd8,              0,30,32'h0,32'd5,1};
    tbl[12] = '{0,0,0,0,33,32'h33,32'd8,              0,30,32'h0,32'd5,2};
    tbl[13] = '{0,0,0,0,33,32'h33,32'd8,              0,30,32'h0,32'd5,3};
    tbl[14] = '{0,0,0,0,33,32'h33,32'd8,              0,30,32'h0,32'd5,4};
    tbl[15] = '{0,0,0,1,34,32'h34,32'd8,              0,30,32'h0,32'd5,0};
    tbl[16] = '{0,0,1,0,40,32'h40,32'd9,              1,40,32'h40,32'd9,0};
    model_reset();
    // reset held with random inputs and running clock
    repeat (4) begin
      drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
            10'($urandom), $urandom, $urandom);
      @(negedge clk);
    end
    check_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1;
    #1 check_reset();
    // vector table
    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].st, tbl[i].v, tbl[i].clr, tbl[i].pc, tbl[i].ir, tbl[i].a);
      #1 chk("of_ready", of_ready, !tbl[i].st);
      step();
      chk("t_valid", ex_valid, tbl[i].ev); chk("t_pc", ex_pc, tbl[i].epc);
      chk("t_ir", ex_ir, tbl[i].eir); chk("t_op_a", ex_op_a, tbl[i].ea);
      chk("t_count", bubble_count, tbl[i].ecnt);
    end
    // asynchronous reset between edges, no clock edge needed
    drive(0, 1, 1, 0, 50, 32'h50, 32'd11);
    @(posedge clk);
    #2 reset_n = 0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    reset_n = 1;
    // saturation on the 3-bit counter instance
    drive(0, 0, 1, 1, 60, 32'h60, 32'd12);
    step();
    chk("sat_clr", s_cnt, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(1, k[0], 1, 0, 61, 32'h61, 32'd13);
      step();
      chk("sat_s_count", s_cnt, (k > 7) ? 7 : k);
      chk("sat_count", bubble_count, k);
      chk("sat_s_ir", s_ir, NOP2);
    end
    // random run against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0,9) == 0, $urandom_range(0,3) == 0, $urandom_range(0,9) < 7,
            $urandom_range(0,29) == 0, 10'($urandom), $urandom, $urandom);
      #1 chk("r_ready", of_ready, !ex_stall);
      step();
      check_model();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
